// File: rtl/gpio_cond_pkg.sv
// Shared types and helpers for the gpio_cond input-conditioning block.
// Holds the per-channel IRQ edge-select encoding and the debounce counter width helper.
package gpio_cond_pkg;

    typedef enum logic [1:0] {
        IRQ_OFF  = 2'b00,
        IRQ_RISE = 2'b01,
        IRQ_FALL = 2'b10,
        IRQ_BOTH = 2'b11
    } irq_mode_t;

    // Counter must be able to represent DEBOUNCE_CYCLES itself.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// One GPIO channel: synchroniser chain, debounce counter and registered
// level / rise / fall outputs.
module gpio_debounce_ch
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            // Accept on the cycle the count would reach DEBOUNCE_CYCLES.
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_cond.sv
// NCH-channel GPIO conditioner: per-channel sync/debounce/edge detect, plus
// sticky pending bits and an IRQ line when GPIO_COND_IRQ_EN is defined.
module gpio_cond
    import gpio_cond_pkg::*;
#(
    parameter int NCH             = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [NCH-1:0]   raw_i,
    output logic [NCH-1:0]   level_o,
    output logic [NCH-1:0]   rise_o,
    output logic [NCH-1:0]   fall_o,
    input  logic [2*NCH-1:0] irq_mode_i,
    input  logic [NCH-1:0]   pend_clr_i,
    output logic [NCH-1:0]   pend_o,
    output logic             irq_o
);

    genvar gi;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            gpio_debounce_ch #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk_i   (clk_i),
                .arst_i  (arst_i),
                .raw_i   (raw_i[gi]),
                .level_o (level_o[gi]),
                .rise_o  (rise_o[gi]),
                .fall_o  (fall_o[gi])
            );
        end
    endgenerate

`ifdef GPIO_COND_IRQ_EN
    logic [NCH-1:0] pend_q, pend_d, pend_set;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_pend
            irq_mode_t mode;
            assign mode = irq_mode_t'(irq_mode_i[2*gi+1 -: 2]);
            assign pend_set[gi] =
                (rise_o[gi] && (mode == IRQ_RISE || mode == IRQ_BOTH)) ||
                (fall_o[gi] && (mode == IRQ_FALL || mode == IRQ_BOTH));
        end
    endgenerate

    // A new event in the same cycle as a clear strobe keeps the bit set.
    always_comb begin
        pend_d = (pend_q & ~pend_clr_i) | pend_set;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
    assign irq_o  = |pend_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_mode_i, pend_clr_i};

    assign pend_o = '0;
    assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_cond.sv
// Directed self-checking bench for gpio_cond (NCH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
module tb_gpio_cond;

`ifdef GPIO_COND_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk;
    logic       arst;
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] pend;
    logic       irq;

    int checks = 0;
    int errors = 0;

    gpio_cond #(
        .NCH             (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .raw_i      (raw),
        .level_o    (level),
        .rise_o     (rise),
        .fall_o     (fall),
        .irq_mode_i (mode),
        .pend_clr_i (clr),
        .pend_o     (pend),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pexp(input logic [3:0] v);
        return IRQ_EN ? v : 4'b0000;
    endfunction

    function automatic logic iexp(input logic v);
        return IRQ_EN ? v : 1'b0;
    endfunction

    initial begin
        arst = 1'b1;
        raw  = 4'hF;
        mode = 8'h00;
        clr  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 4'h0);
        chk("rst_rise", rise, 4'h0);
        chk("rst_fall", fall, 4'h0);
        chk("rst_pend", pend, 4'h0);
        chk("rst_irq", irq, 1'b0);

        // Release with all pins high: level rises at edge 10.
        arst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("rel_level_e%0d", i), level, 4'h0);
            chk($sformatf("rel_rise_e%0d", i), rise, 4'h0);
        end
        tick();
        chk("rel_level_e10", level, 4'hF);
        chk("rel_rise_e10", rise, 4'hF);
        tick();
        chk("rel_rise_e11", rise, 4'h0);
        chk("rel_level_e11", level, 4'hF);

        // Bring everything low.
        raw = 4'h0;
        repeat (9) tick();
        chk("low_level_e9", level, 4'hF);
        tick();
        chk("low_level_e10", level, 4'h0);
        chk("low_fall_e10", fall, 4'hF);
        chk("low_rise_e10", rise, 4'h0);
        tick();
        chk("low_fall_e11", fall, 4'h0);

        // 7-cycle glitch on ch0 is filtered.
        raw[0] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 7) raw[0] = 1'b0;
            chk($sformatf("glitch_level_e%0d", i), level, 4'h0);
            chk($sformatf("glitch_rise_e%0d", i), rise, 4'h0);
        end

        // Held pulse on ch0 is accepted at edge 10.
        raw[0] = 1'b1;
        repeat (9) tick();
        chk("hold_level_e9", level, 4'h0);
        tick();
        chk("hold_level_e10", level, 4'h1);
        chk("hold_rise_e10", rise, 4'h1);
        tick();

        // ch1 RISE, ch2 FALL.
        mode = 8'b00_10_01_00;
        raw[1] = 1'b1;
        repeat (9) tick();
        chk("ch1_level_e9", level, 4'b0001);
        tick();
        chk("ch1_level_e10", level, 4'b0011);
        chk("ch1_rise_e10", rise, 4'b0010);
        chk("ch1_pend_e10", pend, 4'b0000);
        tick();
        chk("ch1_pend_e11", pend, pexp(4'b0010));
        chk("ch1_irq_e11", irq, iexp(1'b1));
        chk("ch1_rise_e11", rise, 4'b0000);

        raw[2] = 1'b1;
        repeat (10) tick();
        chk("ch2_rise_e10", rise, 4'b0100);
        chk("ch2_level_rise", level, 4'b0111);
        tick();
        chk("ch2_rise_nopend", pend, pexp(4'b0010));

        raw[2] = 1'b0;
        repeat (10) tick();
        chk("ch2_fall_e10", fall, 4'b0100);
        chk("ch2_level_fall", level, 4'b0011);
        chk("ch2_pend_e10", pend, pexp(4'b0010));
        tick();
        chk("ch2_pend_e11", pend, pexp(4'b0110));

        // ch1 fall does not match RISE mode.
        raw[1] = 1'b0;
        repeat (10) tick();
        chk("ch1_fall_e10", fall, 4'b0010);
        tick();
        chk("ch1_fall_nopend", pend, pexp(4'b0110));

        // Clear ch1 and ch2 while a new ch1 rise is pulsing: ch1 set wins.
        raw[1] = 1'b1;
        repeat (10) tick();
        chk("clr_rise_e10", rise, 4'b0010);
        clr = 4'b0110;
        tick();
        clr = 4'b0000;
        chk("clr_setwins_pend", pend, pexp(4'b0010));
        chk("clr_setwins_irq", irq, iexp(1'b1));

        clr = 4'b0010;
        tick();
        clr = 4'b0000;
        chk("clr_alone_pend", pend, 4'b0000);
        chk("clr_alone_irq", irq, 1'b0);

        // Re-arm pend_o = 0010.
        raw[1] = 1'b0;
        repeat (11) tick();
        raw[1] = 1'b1;
        repeat (11) tick();
        chk("rearm_pend", pend, pexp(4'b0010));
        chk("rearm_level", level, 4'b0011);

        // ch3 rises; reset at debounce count 5.
        raw[3] = 1'b1;
        repeat (7) tick();
        chk("mid_level_pre", level, 4'b0011);
        arst = 1'b1;
        #1;
        chk("mid_level", level, 4'h0);
        chk("mid_pend", pend, 4'h0);
        chk("mid_irq", irq, 1'b0);
        chk("mid_rise", rise, 4'h0);
        chk("mid_fall", fall, 4'h0);
        tick();
        tick();
        chk("mid_hold_level", level, 4'h0);
        arst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("rerel_level_e%0d", i), level, 4'h0);
        end
        tick();
        chk("rerel_level_e10", level, 4'b1011);
        chk("rerel_rise_e10", rise, 4'b1011);
        tick();
        chk("rerel_pend_e11", pend, pexp(4'b0010));
        chk("rerel_irq_e11", irq, iexp(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
